// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer for the convolution core: streams one image from the image RAM
// into cnn_core and collects its output feature map into the result RAM.
module cnn_frame_ctrl #(
    parameter int unsigned IX        = 28,
    parameter int unsigned KX        = 5,
    parameter int unsigned I_F_BW    = 8,
    parameter int unsigned CO        = 3,
    parameter int unsigned O_F_BW    = 19,
    parameter int unsigned IADDR_BW  = 10,
    parameter int unsigned OADDR_BW  = 10,
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic                   i_hold,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_img_rd_en,
    output logic [IADDR_BW-1:0]    o_img_addr,
    input  logic [I_F_BW-1:0]      i_img_data,
    output logic                   o_core_valid,
    output logic [I_F_BW-1:0]      o_core_fmap,
    input  logic                   i_core_ot_valid,
    input  logic [CO*O_F_BW-1:0]   i_core_ot_fmap,
    output logic                   o_res_we,
    output logic [OADDR_BW-1:0]    o_res_addr,
    output logic [CO*O_F_BW-1:0]   o_res_data
);

    localparam int unsigned NPIX    = IX * IX;
    localparam int unsigned OX      = IX - KX + 1;
    localparam int unsigned NOUT    = OX * OX;
    localparam int unsigned CNT_BW  = OADDR_BW + 1;
    localparam int unsigned IDLE_BW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [IADDR_BW-1:0] pix_cnt;
    logic [CNT_BW-1:0]   out_cnt;
    logic [IDLE_BW-1:0]  idle_cnt;
    logic                rd_q;
    logic                capture;
    logic                last_out;

    // Core results are only accepted while a frame is in flight and not yet full.
    assign capture  = i_core_ot_valid
                    && ((state == S_FEED) || (state == S_DRAIN))
                    && (out_cnt < CNT_BW'(NOUT));
    assign last_out = capture && (out_cnt == CNT_BW'(NOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            out_cnt      <= '0;
            idle_cnt     <= '0;
            rd_q         <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_img_rd_en  <= 1'b0;
            o_img_addr   <= '0;
            o_core_valid <= 1'b0;
            o_core_fmap  <= '0;
            o_res_we     <= 1'b0;
            o_res_addr   <= '0;
            o_res_data   <= '0;
        end else begin
            o_img_rd_en <= 1'b0;
            o_res_we    <= 1'b0;
            o_done      <= 1'b0;

            // rd_q tracks the RAM's own read stage so valid lines up with the data.
            rd_q         <= o_img_rd_en;
            o_core_valid <= rd_q;
            if (rd_q) begin
                o_core_fmap <= i_img_data;
            end

            if (capture) begin
                o_res_we   <= 1'b1;
                o_res_addr <= out_cnt[OADDR_BW-1:0];
                o_res_data <= i_core_ot_fmap;
                out_cnt    <= out_cnt + CNT_BW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state    <= S_FEED;
                        pix_cnt  <= '0;
                        out_cnt  <= '0;
                        idle_cnt <= '0;
                        o_err    <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (last_out) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else if (!i_hold) begin
                        o_img_rd_en <= 1'b1;
                        o_img_addr  <= pix_cnt;
                        pix_cnt     <= pix_cnt + IADDR_BW'(1);
                        if (pix_cnt == IADDR_BW'(NPIX - 1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // A final result in the same cycle as the threshold takes priority.
                    if (last_out) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else if (i_core_ot_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_BW'(DRAIN_MAX - 1)) begin
                        idle_cnt <= IDLE_BW'(DRAIN_MAX);
                        o_err    <= 1'b1;
                        state    <= S_DONE;
                        o_done   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_BW'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Directed bench for cnn_frame_ctrl with an image RAM model, a behavioural conv core
// and a result scoreboard filled from the source image at each start.
module tb_cnn_frame_ctrl;

    localparam int unsigned IX        = 28;
    localparam int unsigned KX        = 5;
    localparam int unsigned I_F_BW    = 8;
    localparam int unsigned CO        = 3;
    localparam int unsigned O_F_BW    = 19;
    localparam int unsigned IADDR_BW  = 10;
    localparam int unsigned OADDR_BW  = 10;
    localparam int unsigned DRAIN_MAX = 64;
    localparam int unsigned NPIX      = IX * IX;
    localparam int unsigned OX        = IX - KX + 1;
    localparam int unsigned NOUT      = OX * OX;
    localparam int unsigned OW        = CO * O_F_BW;

    logic                clk;
    logic                reset_n;
    logic                i_start;
    logic                i_hold;
    logic                o_busy;
    logic                o_done;
    logic                o_err;
    logic                o_img_rd_en;
    logic [IADDR_BW-1:0] o_img_addr;
    logic [I_F_BW-1:0]   i_img_data;
    logic                o_core_valid;
    logic [I_F_BW-1:0]   o_core_fmap;
    logic                i_core_ot_valid;
    logic [OW-1:0]       i_core_ot_fmap;
    logic                o_res_we;
    logic [OADDR_BW-1:0] o_res_addr;
    logic [OW-1:0]       o_res_data;

    cnn_frame_ctrl #(
        .IX(IX), .KX(KX), .I_F_BW(I_F_BW), .CO(CO), .O_F_BW(O_F_BW),
        .IADDR_BW(IADDR_BW), .OADDR_BW(OADDR_BW), .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_hold(i_hold),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_img_rd_en(o_img_rd_en), .o_img_addr(o_img_addr), .i_img_data(i_img_data),
        .o_core_valid(o_core_valid), .o_core_fmap(o_core_fmap),
        .i_core_ot_valid(i_core_ot_valid), .i_core_ot_fmap(i_core_ot_fmap),
        .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [I_F_BW-1:0]   img_mem [NPIX];
    logic [I_F_BW-1:0]   img_rx  [NPIX];
    logic [OW-1:0]       sb_q [$];

    int cyc = 0;
    int rx_cnt, emitted, emit_limit, extra_left;
    int exp_addr, writes, last_res_addr, n_done;
    int done_cyc, err_cyc, last_rd_cyc, lastv_cyc, last_we_cyc, first_rd, first_cv;
    int exp_err_cyc;
    bit aborted;
    bit done_prev;
    bit pend_en;
    logic [IADDR_BW-1:0] pend_addr;
    bit rd_h1, rd_h2;
    logic [IADDR_BW-1:0] a_h1, a_h2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wt(input int ch, input int ky, input int kx);
        return ((ch + 1) * (ky * KX + kx + 1)) % 13;
    endfunction

    function automatic logic [OW-1:0] conv(input bit from_rx, input int oy, input int ox);
        logic [OW-1:0] w;
        w = '0;
        for (int ch = 0; ch < CO; ch++) begin
            int s;
            s = 0;
            for (int ky = 0; ky < KX; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    int idx;
                    idx = (oy + ky) * IX + ox + kx;
                    s += int'(from_rx ? img_rx[idx] : img_mem[idx]) * wt(ch, ky, kx);
                end
            end
            w[ch*O_F_BW +: O_F_BW] = O_F_BW'(s);
        end
        return w;
    endfunction

    task automatic clear_hist();
        pend_en = 1'b0;
        rd_h1 = 1'b0; rd_h2 = 1'b0;
        a_h1 = '0; a_h2 = '0;
        done_prev = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   64'(o_busy), 64'd0);
        check({tag, "_done"},   64'(o_done), 64'd0);
        check({tag, "_err"},    64'(o_err), 64'd0);
        check({tag, "_rd_en"},  64'(o_img_rd_en), 64'd0);
        check({tag, "_addr"},   64'(o_img_addr), 64'd0);
        check({tag, "_cvalid"}, 64'(o_core_valid), 64'd0);
        check({tag, "_cfmap"},  64'(o_core_fmap), 64'd0);
        check({tag, "_we"},     64'(o_res_we), 64'd0);
        check({tag, "_raddr"},  64'(o_res_addr), 64'd0);
        check({tag, "_rdata"},  64'(o_res_data), 64'd0);
    endtask

    // One clock: sample DUT at the falling edge, run RAM/core models, drive core output.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend_en) i_img_data = img_mem[pend_addr];
        pend_en   = o_img_rd_en;
        pend_addr = o_img_addr;

        if (o_img_rd_en) begin
            check("rd_addr", 64'(o_img_addr), 64'(exp_addr));
            exp_addr++;
            last_rd_cyc = cyc;
            if (first_rd < 0) first_rd = cyc;
        end
        check("core_valid", 64'(o_core_valid), 64'(rd_h2));
        if (o_core_valid && rd_h2) check("core_fmap", 64'(o_core_fmap), 64'(img_mem[a_h2]));
        if (o_core_valid && first_cv < 0) first_cv = cyc;
        rd_h2 = rd_h1; a_h2 = a_h1;
        rd_h1 = o_img_rd_en; a_h1 = o_img_addr;

        if (o_res_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(o_res_we), 64'd0);
            end else begin
                logic [OW-1:0] exp_w;
                exp_w = sb_q.pop_front();
                check("res_data", 64'(o_res_data), 64'(exp_w));
                check("res_addr", 64'(o_res_addr), 64'(writes));
            end
            writes++;
            last_res_addr = int'(o_res_addr);
            last_we_cyc = cyc;
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (done_prev) check("busy_after_done", 64'(o_busy), 64'd0);
        done_prev = o_done;
        if (o_err && err_cyc < 0) err_cyc = cyc;

        // Core model: emits each output as soon as its window's last pixel arrives.
        i_core_ot_valid = 1'b0;
        if (o_core_valid && rx_cnt < int'(NPIX)) begin
            int r, c;
            img_rx[rx_cnt] = o_core_fmap;
            r = rx_cnt / IX;
            c = rx_cnt % IX;
            rx_cnt++;
            if (r >= int'(KX) - 1 && c >= int'(KX) - 1 && emitted < emit_limit) begin
                i_core_ot_valid = 1'b1;
                i_core_ot_fmap  = conv(1'b1, r - int'(KX) + 1, c - int'(KX) + 1);
                emitted++;
                lastv_cyc = cyc;
            end
        end else if (extra_left > 0 && emitted == int'(NOUT)) begin
            i_core_ot_valid = 1'b1;
            i_core_ot_fmap  = {OW{1'b1}};
            extra_left--;
        end
    endtask

    task automatic run_frame(input int hold_period, input int limit, input int extra,
                             input bit stray, input bit idle_valid, input int abort_at);
        int post;
        rx_cnt = 0; emitted = 0; emit_limit = limit; extra_left = extra;
        exp_addr = 0; writes = 0; last_res_addr = -1; n_done = 0;
        done_cyc = -1; last_rd_cyc = -1; lastv_cyc = -1; last_we_cyc = -1;
        first_rd = -1; first_cv = -1; aborted = 1'b0; post = 0;
        sb_q.delete();
        for (int i = 0; i < limit && i < int'(NOUT); i++) sb_q.push_back(conv(1'b0, i / OX, i % OX));

        i_start = 1'b1;
        if (idle_valid) begin
            i_core_ot_valid = 1'b1;
            i_core_ot_fmap  = {OW{1'b1}};
        end
        step();
        i_start = 1'b0;
        check("busy_on_start", 64'(o_busy), 64'd1);
        check("err_clear_on_start", 64'(o_err), 64'd0);
        err_cyc = -1;

        for (int n = 0; n < 4000; n++) begin
            bit feeding;
            feeding = exp_addr < int'(NPIX);
            i_hold  = (hold_period > 0) && (n % hold_period == hold_period - 1);
            i_start = stray && (n == 10 || n == 300);
            step();
            if (feeding && hold_period > 0) begin
                check("hold_rd_en", 64'(o_img_rd_en), 64'(!i_hold));
                if (!o_img_rd_en && exp_addr > 0)
                    check("hold_addr", 64'(o_img_addr), 64'(exp_addr - 1));
            end
            if (abort_at >= 0 && o_img_rd_en && int'(o_img_addr) == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (n_done > 0) post++;
            if (post >= 8) break;
        end
        i_hold = 1'b0;
        i_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_hold = 1'b0;
        i_img_data = '0;
        i_core_ot_valid = 1'b0;
        i_core_ot_fmap = '0;
        clear_hist();
        for (int i = 0; i < int'(NPIX); i++) img_mem[i] = I_F_BW'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Plain frame, with a stray core valid alongside the start pulse.
        run_frame(0, NOUT, 0, 1'b0, 1'b1, -1);
        check("t1_done_count", 64'(n_done), 64'd1);
        check("t1_writes", 64'(writes), 64'(NOUT));
        check("t1_reads", 64'(exp_addr), 64'(NPIX));
        check("t1_valid_lag", 64'(first_cv - first_rd), 64'd2);
        check("t1_done_at_last_write", 64'(done_cyc), 64'(last_we_cyc));
        check("t1_last_addr", 64'(last_res_addr), 64'(NOUT - 1));
        check("t1_err", 64'(o_err), 64'd0);
        check("t1_sb_empty", 64'(sb_q.size()), 64'd0);

        // Hold pulse every 7 cycles.
        run_frame(7, NOUT, 0, 1'b0, 1'b0, -1);
        check("t2_done_count", 64'(n_done), 64'd1);
        check("t2_writes", 64'(writes), 64'(NOUT));
        check("t2_reads", 64'(exp_addr), 64'(NPIX));
        check("t2_sb_empty", 64'(sb_q.size()), 64'd0);
        check("t2_err", 64'(o_err), 64'd0);

        // Core stalls after 500 results: drain timeout.
        run_frame(0, 500, 0, 1'b0, 1'b0, -1);
        exp_err_cyc = (lastv_cyc >= last_rd_cyc) ? lastv_cyc + int'(DRAIN_MAX) + 1
                                                 : last_rd_cyc + int'(DRAIN_MAX);
        check("t3_done_count", 64'(n_done), 64'd1);
        check("t3_writes", 64'(writes), 64'd500);
        check("t3_last_addr", 64'(last_res_addr), 64'd499);
        check("t3_err_cycle", 64'(err_cyc), 64'(exp_err_cyc));
        check("t3_done_with_err", 64'(done_cyc), 64'(exp_err_cyc));
        check("t3_err_sticky", 64'(o_err), 64'd1);

        // Starts during a busy frame are ignored; this start clears the sticky error.
        run_frame(0, NOUT, 0, 1'b1, 1'b0, -1);
        check("t4_done_count", 64'(n_done), 64'd1);
        check("t4_writes", 64'(writes), 64'(NOUT));
        check("t4_reads", 64'(exp_addr), 64'(NPIX));
        check("t4_err", 64'(o_err), 64'd0);

        // Asynchronous reset once the pixel counter has reached 400.
        run_frame(0, NOUT, 0, 1'b0, 1'b0, 399);
        check("t5_aborted", 64'(aborted), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        #2;
        reset_n = 1'b1;
        clear_hist();
        sb_q.delete();
        i_core_ot_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_idle_busy", 64'(o_busy), 64'd0);
            check("t5_idle_rd", 64'(o_img_rd_en), 64'd0);
        end
        run_frame(0, NOUT, 0, 1'b0, 1'b0, -1);
        check("t5_first_rd_after_start", 64'(first_rd > 0), 64'd1);
        check("t5_done_count", 64'(n_done), 64'd1);
        check("t5_writes", 64'(writes), 64'(NOUT));

        // Core produces four surplus results.
        run_frame(0, NOUT, 4, 1'b0, 1'b0, -1);
        check("t6_done_count", 64'(n_done), 64'd1);
        check("t6_writes", 64'(writes), 64'(NOUT));
        check("t6_done_at_last_write", 64'(done_cyc), 64'(last_we_cyc));
        check("t6_last_addr", 64'(last_res_addr), 64'(NOUT - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
